// File: rtl/seg7_disp_pkg.sv
// Shared constants and types for the multi-digit score display.
// Segment patterns are active-low, bit order 6543210 (g..a) as on HEX pins.
package seg7_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] DIGIT_SEG [10] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

endpackage

// File: rtl/seg7_digit_dec.sv
// Single BCD digit to active-low 7-segment decoder.
// Ports: digit (4-bit BCD), blank (force all segments off), seg (7 segments).
module seg7_digit_dec
    import seg7_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && digit <= 4'd9) begin
            seg = DIGIT_SEG[digit];
        end
    end

endmodule

// File: rtl/seg7_score_display.sv
// Score display driver: binary score -> BCD (double-dabble, 1 bit/cycle)
// -> latched display register -> NDIGITS active-low 7-segment digits.
// Ports: clk, reset_n (async, active-low); in_valid/in_ready/in_value
// handshake; blank_lz (leading-zero blanking); blink_en (flash display);
// update (1-cycle pulse on display load); leds (digit i at [7i+6:7i]).
module seg7_score_display
    import seg7_disp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NDIGITS   = 3,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_value,
    input  logic                   blank_lz,
    input  logic                   blink_en,
    output logic                   update,
    output logic [NDIGITS*7-1:0]   leds
);

    localparam int BW   = 4 * NDIGITS;
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int BDW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int CMPW = (WIDTH > 24) ? WIDTH : 24;
    localparam logic [CMPW-1:0] LIMIT = CMPW'(10 ** NDIGITS);

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  shift_q;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic [CNTW-1:0]   bit_cnt;
    logic              ovf;
    logic [BW-1:0]     disp;
    logic              disp_ovf;
    logic              disp_valid;
    logic [BDW-1:0]    blink_cnt;
    logic              phase;
    logic              ovf_in;
    logic              accept;
    logic              force_blank;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign ovf_in   = CMPW'(in_value) >= LIMIT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == CNTW'(1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every nibble >= 5 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q    <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            ovf        <= 1'b0;
            disp       <= '0;
            disp_ovf   <= 1'b0;
            disp_valid <= 1'b0;
            update     <= 1'b0;
        end else begin
            update <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shift_q <= in_value;
                        bcd     <= '0;
                        ovf     <= ovf_in;
                        bit_cnt <= CNTW'(WIDTH);
                    end
                end
                SHIFT: begin
                    // Bits pushed past the top nibble are dropped.
                    bcd     <= {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
                    shift_q <= shift_q << 1;
                    bit_cnt <= bit_cnt - CNTW'(1);
                end
                LOAD: begin
                    disp       <= bcd;
                    disp_ovf   <= ovf;
                    disp_valid <= 1'b1;
                    update     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BDW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BDW'(1);
        end
    end

    // Gate phase with blink_en so clearing blink_en shows the digits at once.
    assign force_blank = !disp_valid || (blink_en && phase);

    for (genvar i = 0; i < NDIGITS; i++) begin : g_dig
        logic       lz;
        logic [6:0] seg;

        if (i == 0) begin : g_lsd
            assign lz = 1'b0;
        end else begin : g_upper
            assign lz = blank_lz && (disp[BW-1:4*i] == '0);
        end

        seg7_digit_dec u_dec (
            .digit (disp[4*i +: 4]),
            .blank (force_blank || lz),
            .seg   (seg)
        );

        assign leds[7*i +: 7] = (disp_ovf && !force_blank) ? SEG_DASH : seg;
    end

endmodule

// File: tb/tb_seg7_score_display.sv
// Scoreboard bench for seg7_score_display: a 3-digit and a 2-digit
// instance share stimulus; expected segments come from a decimal model.
module tb_seg7_score_display;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_value = '0;
    logic          blank_lz = 1'b0;
    logic          blink_en = 1'b0;
    logic          in_ready3;
    logic          in_ready2;
    logic          update3;
    logic          update2;
    logic [20:0]   leds3;
    logic [13:0]   leds2;

    int total = 0;
    int bad = 0;
    int upd_cnt = 0;

    typedef struct {
        int v;
        bit lz;
    } item_t;

    item_t sbq[$];

    logic [6:0] segs [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    always #5 clk = ~clk;

    seg7_score_display #(
        .WIDTH(W), .NDIGITS(3), .BLINK_DIV(4)
    ) u_dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .in_ready(in_ready3), .in_value(in_value), .blank_lz(blank_lz),
        .blink_en(blink_en), .update(update3), .leds(leds3)
    );

    seg7_score_display #(
        .WIDTH(W), .NDIGITS(2), .BLINK_DIV(4)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .in_ready(in_ready2), .in_value(in_value), .blank_lz(blank_lz),
        .blink_en(blink_en), .update(update2), .leds(leds2)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] model(int v, int nd, bit lz);
        logic [20:0] r = '1;
        int p = 1;
        if (v >= 10 ** nd) begin
            for (int i = 0; i < nd; i++) r[7*i +: 7] = 7'b0111111;
            return r;
        end
        for (int i = 0; i < nd; i++) begin
            if (!(lz && i > 0 && v < p)) r[7*i +: 7] = segs[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    always @(negedge clk) begin : mon
        item_t it;
        logic [20:0] m2;
        if (reset_n && update3) begin
            upd_cnt++;
            chk("upd2", 32'(update2), 32'd1);
            if (sbq.size() == 0) begin
                chk("spurious_upd", 32'd1, 32'd0);
            end else begin
                it = sbq.pop_front();
                chk("leds3", 32'(leds3), 32'(model(it.v, 3, it.lz)));
                m2 = model(it.v, 2, it.lz);
                chk("leds2", 32'(leds2), 32'(m2[13:0]));
            end
        end
    end

    task automatic wait_ready();
        int k;
        for (k = 0; k < 50; k++) begin
            if (in_ready3) break;
            @(negedge clk);
        end
        if (k == 50) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic start(int v);
        wait_ready();
        @(negedge clk);
        in_valid = 1'b1;
        in_value = W'(v);
        @(posedge clk);
        sbq.push_back('{v: v, lz: blank_lz});
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int busy);
        busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready3) break;
            busy++;
        end
    endtask

    task automatic send(int v);
        int busy;
        start(v);
        wait_done(busy);
        chk("busy_cycles", 32'(busy), 32'd9);
        chk("upd_pulse", 32'(update3), 32'd1);
        @(negedge clk);
        chk("upd_single", 32'(update3), 32'd0);
    endtask

    task automatic blink_run(int n, int v);
        logic [20:0] e3;
        logic [20:0] e2;
        bit off;
        for (int k = 0; k < n; k++) begin
            off = ((k / 4) % 2) == 1;
            e3 = off ? 21'h1FFFFF : model(v, 3, blank_lz);
            e2 = off ? 21'h1FFFFF : model(v, 2, blank_lz);
            chk("blink3", 32'(leds3), 32'(e3));
            chk("blink2", 32'(leds2), 32'(e2[13:0]));
            @(negedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int saved;
        #1;
        chk("rst_leds3", 32'(leds3), 32'h1FFFFF);
        chk("rst_leds2", 32'(leds2), 32'h3FFF);
        chk("rst_ready", 32'(in_ready3), 32'd1);
        chk("rst_update", 32'(update3), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        blank_lz = 1'b1;
        send(7);
        blank_lz = 1'b0;
        send(7);
        send(255);
        blank_lz = 1'b1;
        send(0);
        send(100);
        send(99);
        blank_lz = 1'b0;
        send(37);

        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_leds", 32'(leds3), 32'h1FFFFF);
        chk("arst_ready", 32'(in_ready3), 32'd1);
        chk("arst_update", 32'(update3), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_blank", 32'(leds3), 32'h1FFFFF);

        send(12);
        start(5);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_value = W'(42);
        repeat (3) @(negedge clk);
        chk("hold_during_conv", 32'(leds3), 32'(model(12, 3, blank_lz)));
        chk("busy_ignores", 32'(in_ready3), 32'd0);
        in_valid = 1'b0;
        wait_done(busy);
        @(negedge clk);
        chk("after_ignore", 32'(leds3), 32'(model(5, 3, blank_lz)));

        start(77);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_leds", 32'(leds3), 32'h1FFFFF);
        chk("mid_rst_ready", 32'(in_ready3), 32'd1);
        chk("mid_rst_update", 32'(update3), 32'd0);
        sbq.delete();
        saved = upd_cnt;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("no_upd_after_abort", 32'(upd_cnt), 32'(saved));
        chk("abort_blank", 32'(leds3), 32'h1FFFFF);

        blank_lz = 1'b1;
        send(12);
        @(negedge clk);
        blink_en = 1'b1;
        #1;
        blink_run(16, 12);
        repeat (4) @(negedge clk);
        #1;
        chk("blink_off_phase", 32'(leds3), 32'h1FFFFF);
        blink_en = 1'b0;
        #1;
        chk("blink_clear_now", 32'(leds3), 32'(model(12, 3, 1'b1)));
        repeat (5) begin
            @(negedge clk);
            chk("blink_cleared", 32'(leds3), 32'(model(12, 3, 1'b1)));
        end
        blink_en = 1'b1;
        #1;
        blink_run(8, 12);
        blink_en = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_score_display.md
Name: seg7_score_display

Overview:
- Multi-digit decimal score display driver for the Pong HEX outputs.
- Accepts an unsigned binary score over a valid/ready handshake and converts it to BCD with an iterative double-dabble, one bit per cycle.
- Latches the result and drives NDIGITS active-low 7-segment digits, with optional leading-zero blanking, overflow dashes and blink.
- Sits between the score counters and the HEX pins; replaces per-digit direct 4-bit decoding.

Parameters:
WIDTH, 8, bit width of in_value (>=1)
NDIGITS, 3, number of decimal digits driven (1..6)
BLINK_DIV, 25000000, clk cycles per blink half-period (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_value is presented for conversion
in_ready  output  1  block is idle and can accept a value
in_value  input  WIDTH  unsigned binary score
blank_lz  input  1  1 = blank leading zero digits (digit 0 never blanked)
blink_en  input  1  1 = flash whole display at BLINK_DIV rate
update  output  1  one-cycle pulse when the display register is loaded
leds  output  NDIGITS*7  segments, active-low, digit i at [7i+6:7i], bit order 6543210 as HEX pins

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; BCD, shift and display registers cleared; overflow flag cleared.
  - display_valid=0; update=0; blink counter=0; phase=0.
- Reset outputs: leds all 1 (every digit blank); in_ready=1 (IDLE).
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at edge T: capture in_value into the shift register; clear BCD; set ovf=(in_value >= 10**NDIGITS); load bit counter=WIDTH; go to SHIFT.
  - SHIFT: in_ready=0. Each edge: every BCD nibble >=5 gets +3, then {bcd,shift} shifts left by 1; counter decrements. After WIDTH edges (T+1..T+WIDTH) go to LOAD.
  - LOAD: one edge (T+WIDTH+1). Copy BCD into the display register; copy ovf; set display_valid=1; update=1 for the following cycle; go to IDLE.
- Latency: leds reflect a new value from the cycle after edge T+WIDTH+1; in_ready low for exactly WIDTH+1 cycles after acceptance.
- in_valid while in_ready=0 is ignored and not queued. The display holds the last loaded value during conversion.
- BCD register width is 4*NDIGITS. Bits shifted beyond the top nibble are discarded; correctness is guaranteed only when ovf=0.
- Decode (combinational from the display register):
  - display_valid=0 -> all blank.
  - ovf=1 -> every digit shows dash 7'b0111111.
  - Otherwise each digit shows the standard 0-9 pattern, e.g. 0=1000000, 1=1111001, 7=1111000.
  - blank_lz=1: digit i>0 is blank (7'b1111111) if it and all higher digits are 0.
- Blink:
  - blink_en=0: counter held at 0 and phase=0.
  - blink_en=1: counter counts 0..BLINK_DIV-1; phase toggles at wrap.
  - phase=1 forces all leds to 1. blank_lz and blink_en take effect combinationally.
- Reset mid-conversion aborts, returns to IDLE and blanks the display; no update pulse is issued.
- leds and update are driven from registers or from registered state through the decode only; there are no paths from in_value to leds.

Decomposition:
- Package seg7_disp_pkg holds:
  - SEG_BLANK=7'b1111111 and SEG_DASH=7'b0111111;
  - the 10-entry digit segment constant array;
  - the state enum {IDLE, SHIFT, LOAD}.
- One sub-module, seg7_digit_dec: 4-bit BCD digit plus blank input -> 7 segment outputs, instantiated NDIGITS times via generate.
- The FSM, double-dabble datapath and blink counter stay in the top.

Test Plan:
1. Reset: hold reset_n=0 mid-run -> leds all 1s, in_ready=1, update=0 immediately (asynchronous).
2. WIDTH=8, NDIGITS=3, blank_lz=1, send 7 at edge T -> in_ready=0 for 9 cycles; update pulses after edge T+9; leds = {1111111,1111111,1111000}. Repeat with blank_lz=0 -> {1000000,1000000,1111000}.
3. Send 255 -> digits 2,5,5 = {0100100,0010010,0010010}. Then send 0 with blank_lz=1 -> {blank,blank,1000000}.
4. NDIGITS=2, send 100 -> {0111111,0111111}. Then send 99 -> {0010000,0010000}.
5. Assert in_valid with value 42 during SHIFT of value 5 -> 42 is ignored and the display shows 5. Pull reset_n low mid-SHIFT -> display blank, no update pulse.
6. BLINK_DIV=4, blink_en=1, display 12 -> leds alternate normal/blank every 4 cycles. Clear blink_en -> normal display on the next cycle with the counter held at 0.
